// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide sequencer: op codes, ALU
// control codes, FSM state encodings and small op-decode helpers.
package mdu_pkg;

  typedef enum logic [1:0] {
    OP_MULTU = 2'b00,
    OP_MULT  = 2'b01,
    OP_DIVU  = 2'b10,
    OP_DIV   = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ITER = 2'd1,
    S_FIX  = 2'd2
  } state_e;

  localparam logic [3:0] ALUC_ADDU = 4'b0000;
  localparam logic [3:0] ALUC_SUBU = 4'b0001;

  // Bit 1 of the op code selects divide, bit 0 selects signed.
  function automatic logic op_is_div(op_e op);
    return op[1];
  endfunction

  function automatic logic op_is_signed(op_e op);
    return op[0];
  endfunction

endpackage

// File: rtl/mdu_neg64.sv
// Conditional two's-complement negate. Default width is the 64-bit
// product; narrower instances serve the operand abs() and remainder fix.
module mdu_neg64 #(
  parameter int W = 64
) (
  input  logic [W-1:0] a,
  input  logic         neg,
  output logic [W-1:0] y
);

  assign y = neg ? (~a + W'(1)) : a;

endmodule

// File: rtl/mdu_seq.sv
// Multi-cycle MULT/MULTU/DIV/DIVU sequencer. Borrows the shared ALU for
// 32 shift-add (multiply) or restoring-subtract (divide) iterations, then
// applies sign correction and writes hi/lo in a single FIX cycle.
module mdu_seq
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             alu_sel,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [3:0]       alu_aluc,
  input  logic [WIDTH-1:0] alu_r,
  input  logic             alu_carry
);

  state_e           state_q, state_d;
  op_e              op_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] p_hi_q, p_lo_q;
  logic [WIDTH-1:0] opnd_q;      // multiplicand or divisor, already abs()
  logic             sign_quo_q;  // negate product / quotient in FIX
  logic             sign_rem_q;  // negate remainder in FIX
  logic             dzero_q;     // divisor was zero at start

  op_e  op_in;
  logic in_signed, in_div;
  assign op_in     = op_e'(op);
  assign in_signed = op_is_signed(op_in);
  assign in_div    = op_is_div(op_in);

  // Operand magnitudes; unsigned ops pass straight through.
  logic [WIDTH-1:0] abs_rs, abs_rt;
  mdu_neg64 #(.W(WIDTH)) u_abs_rs (
    .a(rs_val), .neg(in_signed & rs_val[WIDTH-1]), .y(abs_rs)
  );
  mdu_neg64 #(.W(WIDTH)) u_abs_rt (
    .a(rt_val), .neg(in_signed & rt_val[WIDTH-1]), .y(abs_rt)
  );

  // Sign correction: full 64-bit negate for products; for divides the
  // low word of the same instance negates the quotient, and a second
  // instance negates the remainder independently.
  logic [2*WIDTH-1:0] fix_lo_in, fix_lo_out;
  logic [WIDTH-1:0]   fix_hi_out;
  assign fix_lo_in = op_is_div(op_q) ? {{WIDTH{1'b0}}, p_lo_q} : {p_hi_q, p_lo_q};
  mdu_neg64 #(.W(2*WIDTH)) u_fix_lo (
    .a(fix_lo_in), .neg(sign_quo_q), .y(fix_lo_out)
  );
  mdu_neg64 #(.W(WIDTH)) u_fix_hi (
    .a(p_hi_q), .neg(sign_rem_q), .y(fix_hi_out)
  );

  // Restoring-divide step: shift the partial remainder left by one and
  // keep the difference whenever the 33-bit value is >= divisor.
  logic [WIDTH-1:0] shift_val;
  logic             take_sub;
  assign shift_val = {p_hi_q[WIDTH-2:0], p_lo_q[WIDTH-1]};
  assign take_sub  = p_hi_q[WIDTH-1] | ~alu_carry;

  assign busy    = (state_q == S_ITER) || (state_q == S_FIX);
  assign alu_sel = (state_q == S_ITER);

  // ALU operand mux; idle values are zero / ADDU outside ITER.
  // NOTE: every output of an always_comb gets a default first, otherwise
  // a path that skips the assignment infers a latch.
  always_comb begin
    alu_a    = '0;
    alu_b    = '0;
    alu_aluc = ALUC_ADDU;
    if (state_q == S_ITER) begin
      if (op_is_div(op_q)) begin
        alu_a    = shift_val;
        alu_b    = opnd_q;
        alu_aluc = ALUC_SUBU;
      end else begin
        alu_a = p_hi_q;
        alu_b = p_lo_q[0] ? opnd_q : '0;
      end
    end
  end

  // State register.
  // NOTE: sequential logic uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; flush overrides everything, including start.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (start)        state_d = S_ITER;
      S_ITER:  if (cnt_q == '1)  state_d = S_FIX;
      S_FIX:                     state_d = S_IDLE;
      default:                   state_d = S_IDLE;
    endcase
    if (flush) state_d = S_IDLE;
  end

  // Datapath: operand capture, iteration, and result write-back.
  // NOTE: the working registers are reset too; they are few and cheap,
  // and it keeps simulation free of X on the ALU operand outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q       <= OP_MULTU;
      cnt_q      <= '0;
      p_hi_q     <= '0;
      p_lo_q     <= '0;
      opnd_q     <= '0;
      sign_quo_q <= 1'b0;
      sign_rem_q <= 1'b0;
      dzero_q    <= 1'b0;
      hi         <= '0;
      lo         <= '0;
      div_zero   <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      if (!flush) begin
        unique case (state_q)
          S_IDLE: if (start) begin
            op_q       <= op_in;
            cnt_q      <= '0;
            p_hi_q     <= '0;
            p_lo_q     <= in_div ? abs_rs : abs_rt;
            opnd_q     <= in_div ? abs_rt : abs_rs;
            sign_quo_q <= in_signed & (rs_val[WIDTH-1] ^ rt_val[WIDTH-1]);
            sign_rem_q <= in_signed & rs_val[WIDTH-1];
            dzero_q    <= (rt_val == '0);
          end
          S_ITER: begin
            cnt_q <= cnt_q + CNT_W'(1);
            if (op_is_div(op_q)) begin
              p_hi_q <= take_sub ? alu_r : shift_val;
              p_lo_q <= {p_lo_q[WIDTH-2:0], take_sub};
            end else begin
              p_hi_q <= {alu_carry, alu_r[WIDTH-1:1]};
              p_lo_q <= {alu_r[0], p_lo_q[WIDTH-1:1]};
            end
          end
          S_FIX: begin
            done <= 1'b1;
            if (op_is_div(op_q)) begin
              hi       <= fix_hi_out;
              lo       <= dzero_q ? '1 : fix_lo_out[WIDTH-1:0];
              div_zero <= dzero_q;
            end else begin
              hi <= fix_lo_out[2*WIDTH-1:WIDTH];
              lo <= fix_lo_out[WIDTH-1:0];
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mdu_seq.sv
// Self-checking bench for mdu_seq: a behavioural ALU closes the loop,
// a vector table plus random operands feed a result scoreboard, and
// hand-written sequences cover flush, ignored start and async reset.
module tb_mdu_seq;
  import mdu_pkg::*;

  logic        clk, rst_n, start, flush;
  logic [1:0]  op;
  logic [31:0] rs_val, rt_val;
  logic        busy, done, div_zero, alu_sel, alu_carry;
  logic [31:0] hi, lo, alu_a, alu_b, alu_r;
  logic [3:0]  alu_aluc;

  mdu_seq dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op),
    .rs_val(rs_val), .rt_val(rt_val), .flush(flush),
    .busy(busy), .done(done), .div_zero(div_zero), .hi(hi), .lo(lo),
    .alu_sel(alu_sel), .alu_a(alu_a), .alu_b(alu_b), .alu_aluc(alu_aluc),
    .alu_r(alu_r), .alu_carry(alu_carry)
  );

  // Shared ALU: ADDU gives carry-out, SUBU gives borrow (a < b).
  always_comb begin
    if (alu_aluc == 4'b0001) {alu_carry, alu_r} = {1'b0, alu_a} - {1'b0, alu_b};
    else                     {alu_carry, alu_r} = {1'b0, alu_a} + {1'b0, alu_b};
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
  } exp_t;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] rs;
    logic [31:0] rt;
    exp_t        e;
  } vec_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  logic cur_dz;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Reference model built from the language's own arithmetic.
  function automatic exp_t ref_op(input logic [1:0] o, input logic [31:0] a,
                                  input logic [31:0] b, input logic prev_dz);
    exp_t        r;
    logic [63:0] p;
    r.dz = prev_dz;
    case (o)
      2'b00: begin p = {32'b0, a} * {32'b0, b}; r.hi = p[63:32]; r.lo = p[31:0]; end
      2'b01: begin
        p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
        r.hi = p[63:32]; r.lo = p[31:0];
      end
      default: begin
        if (b == 32'h0) begin
          r.hi = a; r.lo = 32'hffff_ffff; r.dz = 1'b1;
        end else if (o == 2'b10) begin
          r.lo = a / b; r.hi = a % b; r.dz = 1'b0;
        end else if (a == 32'h8000_0000 && b == 32'hffff_ffff) begin
          r.lo = 32'h8000_0000; r.hi = 32'h0; r.dz = 1'b0;
        end else begin
          r.lo = $signed(a) / $signed(b); r.hi = $signed(a) % $signed(b); r.dz = 1'b0;
        end
      end
    endcase
    return r;
  endfunction

  task automatic compare_result();
    exp_t e;
    if (sb_q.size() == 0) begin
      check("scoreboard_empty_on_done", 1'b1, 1'b0);
    end else begin
      e = sb_q.pop_front();
      check("hi", hi, e.hi);
      check("lo", lo, e.lo);
      check("div_zero", div_zero, e.dz);
    end
  endtask

  // Issues one operation from the current time (just after an edge) and
  // waits for done. Start is sampled at the next edge T; done must be
  // seen 33 edges later (FIX at T+33).
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input exp_t e, input bit chk_alu, input bit poke_busy);
    bit got;
    int lat;
    op = o; rs_val = a; rt_val = b; start = 1'b1;
    sb_q.push_back(e);
    cur_dz = e.dz;
    @(posedge clk); #1;
    start = 1'b0;
    check("busy_after_start", busy, 1'b1);
    got = 1'b0;
    lat = 0;
    for (int i = 1; i <= 40 && !got; i++) begin
      if (poke_busy && i == 5) begin
        start = 1'b1; op = ~o; rs_val = ~a; rt_val = 32'h5;
      end
      @(posedge clk); #1;
      start = 1'b0;
      if (chk_alu && i == 1) begin
        check("alu_sel_in_iter", alu_sel, 1'b1);
        check("alu_aluc_in_iter", alu_aluc, o[1] ? 4'b0001 : 4'b0000);
      end
      if (done) begin
        got = 1'b1;
        lat = i;
      end
    end
    if (!got) begin
      check("done_timeout", 1'b0, 1'b1);
      void'(sb_q.pop_front());
    end else begin
      check("done_latency", lat, 33);
      compare_result();
    end
  endtask

  vec_t vt[10];

  initial begin
    exp_t        e;
    logic [1:0]  ro;
    logic [31:0] ra, rb, last_hi, last_lo;
    int          nd;

    vt[0] = '{2'b00, 32'hffff_ffff, 32'hffff_ffff, '{32'hffff_fffe, 32'h0000_0001, 1'b0}};
    vt[1] = '{2'b01, 32'hffff_fffd, 32'h0000_0007, '{32'hffff_ffff, 32'hffff_ffeb, 1'b0}};
    vt[2] = '{2'b01, 32'h8000_0000, 32'h8000_0000, '{32'h4000_0000, 32'h0000_0000, 1'b0}};
    vt[3] = '{2'b10, 32'd100,       32'd7,         '{32'd2,         32'd14,        1'b0}};
    vt[4] = '{2'b11, 32'hffff_fff9, 32'h0000_0002, '{32'hffff_ffff, 32'hffff_fffd, 1'b0}};
    vt[5] = '{2'b10, 32'h0000_1234, 32'h0000_0000, '{32'h0000_1234, 32'hffff_ffff, 1'b1}};
    vt[6] = '{2'b00, 32'h0000_0002, 32'h0000_0003, '{32'h0000_0000, 32'h0000_0006, 1'b1}};
    vt[7] = '{2'b11, 32'h8000_0000, 32'hffff_ffff, '{32'h0000_0000, 32'h8000_0000, 1'b0}};
    vt[8] = '{2'b11, 32'h8000_0000, 32'h0000_0000, '{32'h8000_0000, 32'hffff_ffff, 1'b1}};
    vt[9] = '{2'b11, 32'hffff_fff9, 32'hffff_fffe, '{32'hffff_ffff, 32'h0000_0003, 1'b0}};

    rst_n = 1'b0; start = 1'b0; flush = 1'b0; op = 2'b00; rs_val = '0; rt_val = '0;
    cur_dz = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_busy", busy, 1'b0);
    check("reset_done", done, 1'b0);
    check("reset_alu_sel", alu_sel, 1'b0);
    check("reset_hi_lo", {hi, lo}, 64'h0);
    check("reset_div_zero", div_zero, 1'b0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // Vector table, back to back: each start lands in the previous done cycle.
    for (int k = 0; k < 10; k++)
      run_op(vt[k].op, vt[k].rs, vt[k].rt, vt[k].e, (k < 5), (k == 3));

    // After the last done: pulse gone, ALU operands idle.
    @(posedge clk); #1;
    check("done_single_cycle", done, 1'b0);
    check("idle_busy", busy, 1'b0);
    check("idle_alu_ops", {alu_a, alu_b, alu_aluc}, 68'h0);

    // Random operands against the reference model.
    for (int k = 0; k < 16; k++) begin
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      rb = ($urandom_range(0, 5) == 0) ? 32'h0 :
           ($urandom_range(0, 1) == 0) ? 32'($urandom_range(1, 300)) : $urandom;
      e = ref_op(ro, ra, rb, cur_dz);
      run_op(ro, ra, rb, e, 1'b0, 1'b0);
    end

    // Flush at iteration 10: no result, registers untouched.
    last_hi = hi; last_lo = lo;
    e.dz = cur_dz;
    op = 2'b10; rs_val = 32'd999; rt_val = 32'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush_busy", busy, 1'b0);
    nd = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (done) nd++;
    end
    check("flush_no_done", nd, 0);
    check("flush_hi_lo_kept", {hi, lo}, {last_hi, last_lo});
    check("flush_dz_kept", div_zero, e.dz);

    // Flush and start together in IDLE: nothing accepted.
    op = 2'b00; rs_val = 32'd4; rt_val = 32'd4; start = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    check("flush_beats_start", busy, 1'b0);

    // Async reset mid-ITER: outputs clear at once.
    op = 2'b01; rs_val = 32'd12345; rt_val = 32'hffff_ff00; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("rst_mid_busy", busy, 1'b0);
    check("rst_mid_alu_sel", alu_sel, 1'b0);
    check("rst_mid_done", done, 1'b0);
    check("rst_mid_hi_lo", {hi, lo}, 64'h0);
    check("rst_mid_div_zero", div_zero, 1'b0);
    cur_dz = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    e = ref_op(2'b11, 32'hffff_ff9c, 32'd7, cur_dz);
    run_op(2'b11, 32'hffff_ff9c, 32'd7, e, 1'b1, 1'b0);

    check("scoreboard_drained", sb_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
